// File: rtl/touch_grid_decoder.sv
// ---------------------------------------------------------------------------
// touch_grid_decoder
//
// Purpose:
//   Maps raw 12-bit touchscreen coordinates onto a ROWS x COLS grid of equal
//   rectangular cells. Each touch is debounced, and the block then emits
//   one-cycle press and release events tagged with the cell index
//   (row*COLS + col). The block sits between the touch controller and the
//   cube state-entry logic.
//
// Optional feature:
//   TOUCH_GRID_REPEAT_EN - when defined, a held press re-fires press_valid
//   every REPEAT_CYCLES cycles with press_is_repeat=1. When undefined there is
//   no repeat logic and press_is_repeat is tied low.
//
// Ports:
//   clk             in   1      system clock
//   rst_n           in   1      synchronous reset, active low
//   x_touch         in   12     touch X coordinate
//   y_touch         in   12     touch Y coordinate
//   active          in   1      touch coordinates valid this cycle
//   press_valid     out  1      one-cycle pulse: qualified press (or repeat)
//   press_is_repeat out  1      qualifies press_valid as an auto-repeat
//   release_valid   out  1      one-cycle pulse: qualified release
//   held            out  1      a press is currently held
//   cell_idx        out  IDX_W  cell of the held/pressed/released touch
// ---------------------------------------------------------------------------
module touch_grid_decoder #(
    parameter int  X_ORIGIN        = 0,
    parameter int  Y_ORIGIN        = 0,
    parameter int  CELL_W          = 100,
    parameter int  CELL_H          = 100,
    parameter int  COLS            = 3,
    parameter int  ROWS            = 3,
    parameter int  DEBOUNCE_CYCLES = 16,
    parameter int  REPEAT_CYCLES   = 1024,
    localparam int IDX_W           = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [11:0]      x_touch,
    input  logic [11:0]      y_touch,
    input  logic             active,
    output logic             press_valid,
    output logic             press_is_repeat,
    output logic             release_valid,
    output logic             held,
    output logic [IDX_W-1:0] cell_idx
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Exclusive right/bottom edges of the grid; int arithmetic cannot wrap
    // for 12-bit coordinates.
    localparam int X_END = X_ORIGIN + COLS * CELL_W;
    localparam int Y_END = Y_ORIGIN + ROWS * CELL_H;

    if (CELL_W < 1 || CELL_H < 1 || COLS < 1 || COLS > 16 || ROWS < 1 ||
        ROWS > 16 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("touch_grid_decoder: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_QUALIFY,
        S_PRESSED
    } state_t;

    // -----------------------------------------------------------------------
    // Hit decode: a column is the highest boundary the coordinate has passed,
    // so a shared edge belongs to the higher cell and no divider is needed.
    // -----------------------------------------------------------------------
    int               x_pos;
    int               y_pos;
    int               col_n;
    int               row_n;
    logic             hit_c;
    logic [IDX_W-1:0] idx_c;

    // NOTE: every variable gets a default at the top of an always_comb so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        x_pos = int'(x_touch);
        y_pos = int'(y_touch);
        col_n = 0;
        row_n = 0;
        for (int c = 1; c < COLS; c++) begin
            if (x_pos >= X_ORIGIN + c * CELL_W) col_n = c;
        end
        for (int r = 1; r < ROWS; r++) begin
            if (y_pos >= Y_ORIGIN + r * CELL_H) row_n = r;
        end
        hit_c = active && (x_pos >= X_ORIGIN) && (x_pos < X_END) &&
                (y_pos >= Y_ORIGIN) && (y_pos < Y_END);
        idx_c = hit_c ? IDX_W'(row_n * COLS + col_n) : '0;
    end

    // -----------------------------------------------------------------------
    // Stage 1 sample register; the FSM only ever looks at this copy.
    // -----------------------------------------------------------------------
    logic             hit_q;
    logic [IDX_W-1:0] idx_q;

    // NOTE: reset is sampled on the clock edge (synchronous); every flop in
    // this block is a control/state flop, so all of them are reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_q <= 1'b0;
            idx_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of its inputs, independent of statement order.
            hit_q <= hit_c;
            idx_q <= idx_c;
        end
    end

    // -----------------------------------------------------------------------
    // Debounce / press FSM
    // -----------------------------------------------------------------------
    state_t           state_q,    state_d;
    logic [IDX_W-1:0] cand_q,     cand_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [CNT_W-1:0] rel_cnt_q,  rel_cnt_d;
    logic [IDX_W-1:0] cell_idx_q, cell_idx_d;
    logic             press_q,    press_d;
    logic             repeat_q,   repeat_d;
    logic             release_q,  release_d;
    logic             match;

`ifdef TOUCH_GRID_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        rel_cnt_d  = rel_cnt_q;
        cell_idx_d = cell_idx_q;
        press_d    = 1'b0;
        repeat_d   = 1'b0;
        release_d  = 1'b0;
`ifdef TOUCH_GRID_REPEAT_EN
        rep_cnt_d  = rep_cnt_q;
`endif
        match = hit_q && (idx_q == cand_q);

        unique case (state_q)
            S_IDLE: begin
                if (hit_q) begin
                    cand_d = idx_q;
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d    = S_PRESSED;
                        press_d    = 1'b1;
                        cell_idx_d = idx_q;
                        rel_cnt_d  = '0;
`ifdef TOUCH_GRID_REPEAT_EN
                        rep_cnt_d  = '0;
`endif
                    end else begin
                        state_d = S_QUALIFY;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end

            S_QUALIFY: begin
                if (!hit_q) begin
                    state_d = S_IDLE;
                end else if (!match) begin
                    // Finger moved to another cell: restart on the new one.
                    cand_d = idx_q;
                    cnt_d  = CNT_W'(1);
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = S_PRESSED;
                    press_d    = 1'b1;
                    cell_idx_d = cand_q;
                    rel_cnt_d  = '0;
`ifdef TOUCH_GRID_REPEAT_EN
                    rep_cnt_d  = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_PRESSED: begin
                if (match) begin
                    rel_cnt_d = '0;
`ifdef TOUCH_GRID_REPEAT_EN
                    if (rep_cnt_q == REP_LAST) begin
                        press_d   = 1'b1;
                        repeat_d  = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
`endif
                end else begin
                    // Lift-off and slides both count toward release; a
                    // pending release suppresses repeats.
`ifdef TOUCH_GRID_REPEAT_EN
                    rep_cnt_d = '0;
`endif
                    if (rel_cnt_q == CNT_LAST) begin
                        state_d    = S_IDLE;
                        release_d  = 1'b1;
                        cell_idx_d = cand_q;
                        rel_cnt_d  = '0;
                    end else begin
                        rel_cnt_d = rel_cnt_q + CNT_W'(1);
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cand_q     <= '0;
            cnt_q      <= '0;
            rel_cnt_q  <= '0;
            cell_idx_q <= '0;
            press_q    <= 1'b0;
            repeat_q   <= 1'b0;
            release_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            rel_cnt_q  <= rel_cnt_d;
            cell_idx_q <= cell_idx_d;
            press_q    <= press_d;
            repeat_q   <= repeat_d;
            release_q  <= release_d;
        end
    end

`ifdef TOUCH_GRID_REPEAT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) rep_cnt_q <= '0;
        else        rep_cnt_q <= rep_cnt_d;
    end
    assign press_is_repeat = repeat_q;
`else
    assign press_is_repeat = 1'b0;
`endif

    assign press_valid   = press_q;
    assign release_valid = release_q;
    assign held          = (state_q == S_PRESSED);
    assign cell_idx      = cell_idx_q;

endmodule

// File: tb/tb_touch_grid_decoder.sv
// ---------------------------------------------------------------------------
// tb_touch_grid_decoder
//
// Purpose:
//   Self-checking bench for touch_grid_decoder with a 3x3 grid of 100x100
//   cells, DEBOUNCE_CYCLES=4 and REPEAT_CYCLES=8. A reference model tracks
//   touches as run lengths of decoded samples (cell found by division) and
//   is compared against every output each cycle; directed scenarios add
//   explicit event-count and timing checks. Honours TOUCH_GRID_REPEAT_EN.
// ---------------------------------------------------------------------------
module tb_touch_grid_decoder;

    localparam int X0   = 0;
    localparam int Y0   = 0;
    localparam int CW   = 100;
    localparam int CH   = 100;
    localparam int NC   = 3;
    localparam int NR   = 3;
    localparam int DEB  = 4;
    localparam int REP  = 8;
    localparam int IDXW = 4;
`ifdef TOUCH_GRID_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic            clk     = 1'b0;
    logic            rst_n   = 1'b0;
    logic            active  = 1'b0;
    logic [11:0]     x_touch = '0;
    logic [11:0]     y_touch = '0;
    logic            press_valid;
    logic            press_is_repeat;
    logic            release_valid;
    logic            held;
    logic [IDXW-1:0] cell_idx;

    touch_grid_decoder #(
        .X_ORIGIN       (X0),
        .Y_ORIGIN       (Y0),
        .CELL_W         (CW),
        .CELL_H         (CH),
        .COLS           (NC),
        .ROWS           (NR),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .x_touch        (x_touch),
        .y_touch        (y_touch),
        .active         (active),
        .press_valid    (press_valid),
        .press_is_repeat(press_is_repeat),
        .release_valid  (release_valid),
        .held           (held),
        .cell_idx       (cell_idx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: one-cycle-delayed decoded sample, then run
    // lengths of matching / non-matching samples.
    int m_s1     = -1;
    bit m_held   = 1'b0;
    int m_cand   = 0;
    int m_streak = 0;
    int m_miss   = 0;
    int m_rep    = 0;
    int m_idx    = 0;
    bit e_press, e_rep, e_rel;

    // Per-window observations of the DUT for directed checks.
    int win_edge, win_press, win_rep, win_rel, win_first;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_cell(input bit act, input int x, input int y);
        int c, r;
        if (!act || x < X0 || y < Y0) return -1;
        c = (x - X0) / CW;
        r = (y - Y0) / CH;
        if (c >= NC || r >= NR) return -1;
        return r * NC + c;
    endfunction

    // Called right after a rising edge, before any input changes, so it
    // sees the same inputs the DUT sampled.
    task automatic model_edge();
        int s;
        e_press = 1'b0;
        e_rep   = 1'b0;
        e_rel   = 1'b0;
        if (!rst_n) begin
            m_s1 = -1; m_held = 1'b0; m_cand = 0; m_streak = 0;
            m_miss = 0; m_rep = 0; m_idx = 0;
            return;
        end
        s = m_s1;
        if (!m_held) begin
            if (s < 0)                               m_streak = 0;
            else if (m_streak > 0 && s == m_cand)    m_streak++;
            else begin m_cand = s; m_streak = 1; end
            if (m_streak == DEB) begin
                m_held = 1'b1; e_press = 1'b1; m_idx = m_cand;
                m_streak = 0; m_miss = 0; m_rep = 0;
            end
        end else if (s == m_cand) begin
            m_miss = 0;
            m_rep++;
            if (REP_EN && m_rep == REP) begin
                e_press = 1'b1; e_rep = 1'b1; m_rep = 0;
            end
        end else begin
            m_rep = 0;
            m_miss++;
            if (m_miss == DEB) begin
                m_held = 1'b0; e_rel = 1'b1; m_idx = m_cand; m_streak = 0;
            end
        end
        m_s1 = ref_cell(active, int'(x_touch), int'(y_touch));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        win_edge++;
        check("press_valid",     32'(press_valid),     32'(e_press));
        check("press_is_repeat", 32'(press_is_repeat), 32'(e_rep));
        check("release_valid",   32'(release_valid),   32'(e_rel));
        check("held",            32'(held),            32'(m_held));
        check("cell_idx",        32'(cell_idx),        32'(m_idx));
        if (press_valid) begin
            win_press++;
            if (press_is_repeat) win_rep++;
            if (win_first == 0) win_first = win_edge;
        end
        if (release_valid) win_rel++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic win_clear();
        win_edge = 0; win_press = 0; win_rep = 0; win_rel = 0; win_first = 0;
    endtask

    task automatic drive(input bit a, input int x, input int y);
        active  = a;
        x_touch = 12'(x);
        y_touch = 12'(y);
    endtask

    task automatic lift();
        drive(1'b0, 0, 0);
        run(8);
    endtask

    initial begin
        int bx[8];
        bx = '{0, 99, 100, 199, 200, 299, 300, 301};

        // Reset state
        rst_n = 1'b0;
        run(2);
        check("rst_press",   32'(press_valid),   32'd0);
        check("rst_release", 32'(release_valid), 32'd0);
        check("rst_held",    32'(held),          32'd0);
        check("rst_idx",     32'(cell_idx),      32'd0);
        rst_n = 1'b1;
        run(3);

        // Centre cell held 20 cycles: press at edge 5 on cell 4
        drive(1'b1, 150, 150);
        win_clear();
        run(20);
        check("centre_presses", 32'(win_press), REP_EN ? 32'd2 : 32'd1);
        check("centre_edge",    32'(win_first), 32'd5);
        check("centre_idx",     32'(cell_idx),  32'd4);
        check("centre_held",    32'(held),      32'd1);

        // Release: release_valid at edge 5 of no-hit, cell_idx kept
        drive(1'b0, 0, 0);
        win_clear();
        run(6);
        check("release_count", 32'(win_rel),  32'd1);
        check("release_held",  32'(held),     32'd0);
        check("release_idx",   32'(cell_idx), 32'd4);

        // Boundaries
        drive(1'b1, 99, 0);  win_clear(); run(6);
        check("edge99_idx", 32'(cell_idx), 32'd0);
        check("edge99_n",   32'(win_press), 32'd1);
        lift();
        drive(1'b1, 100, 0); win_clear(); run(6);
        check("edge100_idx", 32'(cell_idx), 32'd1);
        lift();
        drive(1'b1, 299, 299); win_clear(); run(6);
        check("edge299_idx", 32'(cell_idx), 32'd8);
        lift();
        drive(1'b1, 300, 150); win_clear(); run(10);
        check("x300_none", 32'(win_press), 32'd0);
        drive(1'b1, 150, 300); win_clear(); run(10);
        check("y300_none", 32'(win_press), 32'd0);
        lift();

        // Slide before qualification: only cell 5 is pressed
        win_clear();
        drive(1'b1, 150, 150); run(3);
        drive(1'b1, 250, 150); run(10);
        check("slide_presses", 32'(win_press), 32'd1);
        check("slide_idx",     32'(cell_idx),  32'd5);
        lift();

        // Brief lift while pressed does not release
        drive(1'b1, 150, 150); run(8);
        win_clear();
        drive(1'b0, 0, 0);     run(3);
        drive(1'b1, 150, 150); run(3);
        check("glitch_norel", 32'(win_rel), 32'd0);
        check("glitch_held",  32'(held),    32'd1);
        win_clear();
        drive(1'b0, 0, 0);     run(6);
        check("glitch_rel",     32'(win_rel),  32'd1);
        check("glitch_rel_idx", 32'(cell_idx), 32'd4);
        check("glitch_held0",   32'(held),     32'd0);

        // Reset mid-press, then re-press
        drive(1'b1, 150, 150); run(8);
        rst_n = 1'b0;
        win_clear();
        run(1);
        check("abort_held", 32'(held),          32'd0);
        check("abort_rel",  32'(release_valid), 32'd0);
        check("abort_idx",  32'(cell_idx),      32'd0);
        rst_n = 1'b1;
        win_clear();
        run(8);
        check("repress_n",    32'(win_press), 32'd1);
        check("repress_edge", 32'(win_first), 32'd5);
        check("repress_idx",  32'(cell_idx),  32'd4);
        lift();

        // Long hold on cell 8: repeats only with the feature enabled
        drive(1'b1, 250, 250);
        win_clear();
        run(30);
        check("hold8_presses", 32'(win_press), REP_EN ? 32'd4 : 32'd1);
        check("hold8_repeats", 32'(win_rep),   REP_EN ? 32'd3 : 32'd0);
        check("hold8_idx",     32'(cell_idx),  32'd8);
        lift();

        // Randomized segments checked cycle by cycle against the model
        for (int seg = 0; seg < 150; seg++) begin
            int kind;
            int len;
            kind = int'($urandom_range(0, 9));
            len  = int'($urandom_range(1, 12));
            case (kind)
                0, 1:    drive(1'b0, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
                2:       drive(1'b1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
                3:       drive(1'b1, bx[$urandom_range(0, 7)], bx[$urandom_range(0, 7)]);
                9: begin
                    rst_n = 1'b0;
                    run(1);
                    rst_n = 1'b1;
                end
                default: drive(1'b1, int'($urandom_range(0, 299)), int'($urandom_range(0, 299)));
            endcase
            run(len);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
